// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and default widths.
package shift_sequencer_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// One-bit logical shifter datapath; overflow flags the bit pushed off the end.
module shift_sequencer_shifter #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             sel,
  output logic             overflow,
  output logic [WIDTH-1:0] outShift
);

  always_comb begin
    if (sel) begin
      outShift = {1'b0, a[WIDTH-1:1]};
      overflow = a[0];
    end else begin
      outShift = {a[WIDTH-2:0], 1'b0};
      overflow = a[WIDTH-1];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-N controller iterating a 1-bit shifter once per clock.
// Optional EARLY_EXIT_EN: leave SHIFT as soon as the work value becomes zero.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic             sel,
  input  logic [CNT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               sel_q, sel_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   shift_out;
  logic               shift_ovf;

  shift_sequencer_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .a        (work_q),
    .sel      (sel_q),
    .overflow (shift_ovf),
    .outShift (shift_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      sel_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    sel_d   = sel_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = a;
          sel_d   = sel;
          count_d = amount;
          ovf_d   = 1'b0;
          state_d = (amount == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d  = shift_out;
        ovf_d   = ovf_q | shift_ovf;
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
`ifdef EARLY_EXIT_EN
        // A zero work value cannot change result or overflow any further.
        else if (shift_out == '0) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = work_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (honours EARLY_EXIT_EN when defined).
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic        sel;
  logic [3:0]  amount;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .sel      (sel),
    .amount   (amount),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op from an IDLE cycle; optionally keep hammering start while busy.
  task automatic run_op(input string tag, input logic [15:0] a_v, input logic sel_v,
                        input logic [3:0] amt_v, input logic [15:0] exp_res,
                        input logic exp_ovf, input int exp_edges, input bit hold);
    int edges;
    int busy_cycles;
    a = a_v;
    sel = sel_v;
    amount = amt_v;
    start = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    busy_cycles = 0;
    while (1) begin
      if (hold) begin
        start = 1'b1;
        a = 16'hFFFF;
        sel = 1'b1;
        amount = 4'hF;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cycles++;
      if (done || edges >= 40) break;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(exp_edges));
    check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(exp_edges));
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " result_hold"}, 32'(result), 32'(exp_res));
    $display("op %s: a=%h sel=%0d amt=%0d -> result=%h ovf=%0d edges=%0d",
             tag, a_v, sel_v, amt_v, result, overflow, edges);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    sel = 1'b0;
    amount = '0;
    #2;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: asynchronous reset in the middle of a shift
    a = 16'h00FF; sel = 1'b0; amount = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre-reset result", 32'(result), 32'h03FC);
    rst = 1'b1;
    #1;
    check("async busy", 32'(busy), 32'd0);
    check("async done", 32'(done), 32'd0);
    check("async result", 32'(result), 32'd0);
    check("async overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("no done after reset", 32'(seen_done), 32'd0);
    $display("op reset: aborted shift, seen_done=%0d", seen_done);

    // Tests 2-4
    run_op("t2 lsl4", 16'h0001, 1'b0, 4'd4, 16'h0010, 1'b0, 5, 1'b0);
    run_op("t3 lsl1", 16'h8001, 1'b0, 4'd1, 16'h0002, 1'b1, 2, 1'b0);
    run_op("t3 lsr4", 16'h00F0, 1'b1, 4'd4, 16'h000F, 1'b0, 5, 1'b0);
    run_op("t4 lsr5", 16'h00F0, 1'b1, 4'd5, 16'h0007, 1'b1, 6, 1'b0);
    run_op("t4 amt0", 16'h1234, 1'b0, 4'd0, 16'h1234, 1'b0, 1, 1'b0);

    // Test 5: start held during SHIFT/DONE is ignored, next IDLE start accepted
    run_op("t5 hold", 16'h0001, 1'b0, 4'd4, 16'h0010, 1'b0, 5, 1'b1);
    run_op("t5 b2b", 16'h00FF, 1'b0, 4'd2, 16'h03FC, 1'b0, 3, 1'b0);

    // Test 6 and boundaries
`ifdef EARLY_EXIT_EN
    run_op("t6 lsr15", 16'h0003, 1'b1, 4'd15, 16'h0000, 1'b1, 3, 1'b0);
    run_op("zero lsl3", 16'h0000, 1'b0, 4'd3, 16'h0000, 1'b0, 2, 1'b0);
`else
    run_op("t6 lsr15", 16'h0003, 1'b1, 4'd15, 16'h0000, 1'b1, 16, 1'b0);
    run_op("zero lsl3", 16'h0000, 1'b0, 4'd3, 16'h0000, 1'b0, 4, 1'b0);
`endif
    run_op("max lsl15", 16'hFFFF, 1'b0, 4'd15, 16'h8000, 1'b1, 16, 1'b0);
    run_op("lsr1 noovf", 16'hA5A4, 1'b1, 4'd1, 16'h52D2, 1'b0, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
